// File: rtl/vdp_super_pkg.sv
// Shared types and constants for the vdp_super palette stage.
package vdp_super_pkg;

   localparam int PAL_CH_W = 8;
   localparam logic [3*PAL_CH_W-1:0] BLANK_RGB_DEFAULT = 24'h000000;

   typedef struct packed {
      logic [PAL_CH_W-1:0] r;
      logic [PAL_CH_W-1:0] g;
      logic [PAL_CH_W-1:0] b;
   } palette_rgb_t;

   typedef enum logic [1:0] {
      PH_R = 2'd0,
      PH_G = 2'd1,
      PH_B = 2'd2
   } phase_t;

   function automatic palette_rgb_t pack_rgb(input logic [PAL_CH_W-1:0] r,
                                             input logic [PAL_CH_W-1:0] g,
                                             input logic [PAL_CH_W-1:0] b);
      palette_rgb_t c;
      c.r = r;
      c.g = g;
      c.b = b;
      return c;
   endfunction

endpackage

// File: rtl/vdp_super_palette_ram.sv
// Simple dual-port palette RAM (one write, one registered read).
// A same-address write and read returns the old word.
module vdp_super_palette_ram #(
   parameter int AW = 8,
   parameter int DW = 24
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [0:(2**AW)-1];
   logic [DW-1:0] r_q;

   // No reset on storage or read register so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_q <= r_mem[i_raddr];
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/vdp_super_palette.sv
// Palette lookup stage for vdp_super: index -> RGB with 2-clock latency,
// plus the CPU byte-wise entry loader that commits whole colours atomically.
module vdp_super_palette
   import vdp_super_pkg::*;
#(
   parameter int                 IDX_W     = 8,
   parameter int                 CH_W      = 8,
   parameter logic [3*CH_W-1:0]  BLANK_RGB = BLANK_RGB_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 vdp_super,
   input  logic                 disp_on,
   input  logic [IDX_W-1:0]     pix_idx,
   input  logic                 pix_valid,
   input  logic                 pal_idx_wr,
   input  logic                 pal_data_wr,
   input  logic [7:0]           pal_wr_data,
   output logic [3*CH_W-1:0]    rgb_out,
   output logic                 rgb_valid,
   output logic                 pal_wr_busy
);

   phase_t              r_phase;
   logic [IDX_W-1:0]    r_ptr;
   logic [CH_W-1:0]     r_stage_r;
   logic [CH_W-1:0]     r_stage_g;

   logic [CH_W-1:0]     w_byte;
   logic [3*CH_W-1:0]   w_commit;
   logic                w_we;
   logic [3*CH_W-1:0]   w_ram_q;

   logic                r_valid_d;
   logic                r_disp_d;
   logic [3*CH_W-1:0]   r_rgb_out;
   logic                r_rgb_valid;

   assign w_byte   = CH_W'(pal_wr_data);
   assign w_commit = {r_stage_r, r_stage_g, w_byte};
   assign w_we     = pal_data_wr & ~pal_idx_wr & (r_phase == PH_B);

   // Index strobe has priority: it re-aims the pointer and discards any staged bytes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_phase   <= PH_R;
         r_ptr     <= '0;
         r_stage_r <= '0;
         r_stage_g <= '0;
      end else if (pal_idx_wr) begin
         r_phase <= PH_R;
         r_ptr   <= pal_wr_data[IDX_W-1:0];
      end else if (pal_data_wr) begin
         case (r_phase)
            PH_R: begin
               r_stage_r <= w_byte;
               r_phase   <= PH_G;
            end
            PH_G: begin
               r_stage_g <= w_byte;
               r_phase   <= PH_B;
            end
            PH_B: begin
               r_ptr   <= r_ptr + 1'b1;
               r_phase <= PH_R;
            end
            default: r_phase <= PH_R;
         endcase
      end
   end

   assign pal_wr_busy = (r_phase != PH_R);

   vdp_super_palette_ram #(
      .AW (IDX_W),
      .DW (3*CH_W)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_ptr),
      .i_wdata (w_commit),
      .i_raddr (pix_idx),
      .o_rdata (w_ram_q)
   );

   // Qualifiers are gated by vdp_super at C1 so the output blanks two clocks after it drops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid_d   <= 1'b0;
         r_disp_d    <= 1'b0;
         r_rgb_out   <= BLANK_RGB;
         r_rgb_valid <= 1'b0;
      end else begin
         r_valid_d   <= pix_valid & vdp_super;
         r_disp_d    <= disp_on & vdp_super;
         r_rgb_out   <= (r_disp_d & r_valid_d) ? w_ram_q : BLANK_RGB;
         r_rgb_valid <= r_valid_d;
      end
   end

   assign rgb_out   = r_rgb_out;
   assign rgb_valid = r_rgb_valid;

endmodule
